// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin scheduler that shares one uart_tx datapath among NUM_REQ byte requesters.
// Latency: req in IDLE -> ack next posedge; tx_send rises one cycle after ack.
// Backpressure: a requester holds req until it sees ack. Frames are serialised, with a GAP_CYCLES idle gap between them.
// Optional: define TX_TIMEOUT_EN to enable the per-frame watchdog (err pulses, frame abort).
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GNT_W          = 2,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [4*NUM_REQ-1:0] req_cfg,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   done,
  output logic [NUM_REQ-1:0]   err,
  output logic                 busy,
  output logic [GNT_W-1:0]     grant_id,
  output logic                 tx_send,
  output logic [7:0]           tx_data,
  output logic [1:0]           tx_parity_type,
  output logic                 tx_stop_bits,
  output logic                 tx_data_length,
  input  logic                 tx_active,
  input  logic                 tx_done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT_DN = 3'd2,
    S_FINISH  = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [GNT_W-1:0] LAST_ID  = GNT_W'(NUM_REQ - 1);
  // With no gap configured, a finished or aborted frame returns straight to IDLE.
  localparam state_t           POST_FRAME = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;

  state_t            state_q, state_d;
  logic [GNT_W-1:0]  ptr_q;
  logic [GNT_W-1:0]  sel;
  logic              sel_vld;
  logic [GNT_W:0]    scan_sum;
  logic [GNT_W-1:0]  scan_idx;
  logic [7:0]        sel_dat;
  logic [3:0]        sel_cfg;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic              tx_done_prev;
  logic              tx_rise;
  logic              timeout_hit;
  logic              frame_abort;
  logic              grant_now;
  logic [GNT_W-1:0]  ptr_next;

  assign busy      = (state_q != S_IDLE);
  assign tx_rise   = tx_done & ~tx_done_prev;
  assign grant_now = (state_q == S_IDLE) && sel_vld;
  assign ptr_next  = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
  assign sel_dat   = req_data[{sel, 3'b000} +: 8];
  assign sel_cfg   = req_cfg[{sel, 2'b00} +: 4];

  // Watchdog fires only when the frame has not advanced in the same cycle.
  assign frame_abort = timeout_hit &&
                       (((state_q == S_START)   && !tx_active) ||
                        ((state_q == S_WAIT_DN) && !tx_rise));

  // Round-robin scan: the first set request at or above ptr, wrapping. Scanning downward makes the smallest offset win.
  always_comb begin
    sel      = ptr_q;
    sel_vld  = 1'b0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_sum = {1'b0, ptr_q} + (GNT_W+1)'(k);
      if (scan_sum >= (GNT_W+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (GNT_W+1)'(NUM_REQ);
      end
      scan_idx = scan_sum[GNT_W-1:0];
      if (req[scan_idx]) begin
        sel     = scan_idx;
        sel_vld = 1'b1;
      end
    end
  end

  // Next-state logic. A stale tx_done is ignored in START; only a fresh rising edge in WAIT_DN ends the frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (sel_vld) state_d = S_START;
      S_START:   begin
        if (tx_active)        state_d = S_WAIT_DN;
        else if (timeout_hit) state_d = POST_FRAME;
      end
      S_WAIT_DN: begin
        if (tx_rise)          state_d = S_FINISH;
        else if (timeout_hit) state_d = POST_FRAME;
      end
      S_FINISH:  state_d = POST_FRAME;
      S_GAP:     if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Capture the winner's byte and config at grant. They are held until the next grant, so later requester changes are invisible.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      grant_id       <= '0;
      tx_data        <= '0;
      tx_parity_type <= '0;
      tx_stop_bits   <= 1'b0;
      tx_data_length <= 1'b0;
    end else if (grant_now) begin
      grant_id       <= sel;
      tx_data        <= sel_dat;
      tx_parity_type <= sel_cfg[3:2];
      tx_stop_bits   <= sel_cfg[1];
      tx_data_length <= sel_cfg[0];
    end
  end

  // One-cycle ack/done pulses, aligned with the first cycle of START and with FINISH.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      ack  <= '0;
      done <= '0;
    end else begin
      ack  <= grant_now ? (NUM_REQ'(1) << sel) : '0;
      done <= ((state_q == S_WAIT_DN) && tx_rise) ? (NUM_REQ'(1) << grant_id) : '0;
    end
  end

  // After every completed or aborted frame, rotate priority to the client after the last grant.
  always_ff @(posedge clock or posedge rst) begin
    if (rst)                                     ptr_q <= '0;
    else if ((state_q == S_FINISH) || frame_abort) ptr_q <= ptr_next;
  end

  // Send is asserted from the second START cycle through WAIT_DN, giving ack a cycle of lead over tx_send.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) tx_send <= 1'b0;
    else     tx_send <= ((state_d == S_START) || (state_d == S_WAIT_DN)) && (state_q != S_IDLE);
  end

  // Previous tx_done sample, used for rising-edge detection.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) tx_done_prev <= 1'b0;
    else     tx_done_prev <= tx_done;
  end

  // The inter-frame gap counter runs only in GAP and restarts from zero on each entry.
  always_ff @(posedge clock or posedge rst) begin
    if (rst)                    gap_cnt_q <= '0;
    else if (state_q != S_GAP)  gap_cnt_q <= '0;
    else                        gap_cnt_q <= gap_cnt_q + 1'b1;
  end

`ifdef TX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;

  // Cycle count across START/WAIT_DN. It is cleared at grant (entry to START) and expires when it reaches TIMEOUT_CYCLES.
  always_ff @(posedge clock or posedge rst) begin
    if (rst)                                               to_cnt_q <= '0;
    else if (grant_now)                                    to_cnt_q <= '0;
    else if ((state_q == S_START) || (state_q == S_WAIT_DN)) to_cnt_q <= to_cnt_q + 1'b1;
  end

  assign timeout_hit = ((state_q == S_START) || (state_q == S_WAIT_DN)) &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // An aborted frame reports err instead of done.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) err <= '0;
    else     err <= frame_abort ? (NUM_REQ'(1) << grant_id) : '0;
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
  assign err            = '0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter. It uses a behavioural uart_tx model and directed scenarios.
// Expected ack/done/err events are queued by the stimulus and consumed by a negedge monitor.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 4;
  localparam int GNT_W   = 2;
  localparam int GAP     = 16;
  localparam int TB_TO   = 50;
  localparam int EV_ACK  = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  typedef struct {
    int         kind;
    int         id;
    logic [7:0] data;
    logic [3:0] cfg;
  } ev_t;

  logic        clock;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [15:0] req_cfg;
  logic [3:0]  ack, done, err;
  logic        busy;
  logic [1:0]  grant_id;
  logic        tx_send;
  logic [7:0]  tx_data;
  logic [1:0]  tx_parity_type;
  logic        tx_stop_bits, tx_data_length;
  logic        tx_active, tx_done;

  ev_t  exp_q[$];
  int   n_pass = 0, n_total = 0;
  int   ack_cnt = 0, done2_cnt = 0, cyc = 0, last_ack_cyc = 0, err_lat = -1;
  bit   model_en = 1'b1;
  int   act_delay = 2;
  int   frame_len = 5;
  bit   gap_mon_en = 1'b0;
  bit   seen_pulse = 1'b0;
  int   low_run = 0;
  logic [7:0] cl_data[4];
  logic [3:0] cl_cfg[4];

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .GNT_W(GNT_W), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TB_TO)
  ) dut (
    .clock(clock), .rst(rst), .req(req), .req_data(req_data), .req_cfg(req_cfg),
    .ack(ack), .done(done), .err(err), .busy(busy), .grant_id(grant_id),
    .tx_send(tx_send), .tx_data(tx_data), .tx_parity_type(tx_parity_type),
    .tx_stop_bits(tx_stop_bits), .tx_data_length(tx_data_length),
    .tx_active(tx_active), .tx_done(tx_done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic apply_clients();
    for (int i = 0; i < 4; i++) begin
      req_data[8*i +: 8] = cl_data[i];
      req_cfg[4*i +: 4]  = cl_cfg[i];
    end
  endtask

  task automatic push_ev(input int kind, input int id);
    ev_t e;
    e.kind = kind;
    e.id   = id;
    e.data = cl_data[id];
    e.cfg  = cl_cfg[id];
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input int id);
    push_ev(EV_ACK, id);
    push_ev(EV_DONE, id);
  endtask

  task automatic sb_pop(input int kind, input logic [3:0] pulse);
    ev_t        e;
    logic [3:0] oh;
    if (exp_q.size() == 0) begin
      check("sb_unexpected_pulse", 32'(pulse), 32'd0);
    end else begin
      e  = exp_q.pop_front();
      oh = 4'(1 << e.id);
      check("sb_kind", 32'(kind), 32'(e.kind));
      check("sb_onehot", 32'(pulse), 32'(oh));
      if (kind == EV_ACK) begin
        check("sb_grant_id", 32'(grant_id), 32'(e.id));
        check("sb_tx_data", 32'(tx_data), 32'(e.data));
        check("sb_tx_cfg", 32'({tx_parity_type, tx_stop_bits, tx_data_length}), 32'(e.cfg));
      end
    end
  endtask

  // Monitor: every pulse on ack/done/err must match the head of the expected queue.
  initial forever begin
    @(negedge clock);
    if (!rst) begin
      if (ack !== 4'd0) begin
        ack_cnt++;
        last_ack_cyc = cyc;
        sb_pop(EV_ACK, ack);
      end
      if (done !== 4'd0) begin
        if (done[2]) done2_cnt++;
        sb_pop(EV_DONE, done);
      end
      if (err !== 4'd0) begin
        err_lat = cyc - last_ack_cyc;
        sb_pop(EV_ERR, err);
      end
    end
  end

  // Low time between send pulses: FINISH + GAP cycles + IDLE (grant) + first START cycle.
  initial forever begin
    @(negedge clock);
    if (gap_mon_en) begin
      if (tx_send) begin
        if (seen_pulse && low_run > 0) check("t2_gap_len", 32'(low_run), 32'(GAP + 3));
        seen_pulse = 1'b1;
        low_run    = 0;
      end else if (seen_pulse) begin
        low_run++;
      end
    end else begin
      seen_pulse = 1'b0;
      low_run    = 0;
    end
  end

  // uart_tx model: after act_delay cycles of send it goes active; after frame_len cycles it raises tx_done and holds it as a level.
  initial begin
    int mcnt;
    int mst;
    mcnt = 0;
    mst  = 0;
    tx_active = 1'b0;
    tx_done   = 1'b0;
    forever begin
      @(negedge clock);
      if (rst || !model_en) begin
        tx_active = 1'b0;
        if (rst) tx_done = 1'b0;
        mst  = 0;
        mcnt = 0;
      end else begin
        case (mst)
          0: if (tx_send) begin
               mcnt++;
               if (mcnt >= act_delay) begin
                 tx_active = 1'b1;
                 tx_done   = 1'b0;
                 mcnt      = 0;
                 mst       = 1;
               end
             end else mcnt = 0;
          1: begin
               mcnt++;
               if (mcnt >= frame_len) begin
                 tx_active = 1'b0;
                 tx_done   = 1'b1;
                 mcnt      = 0;
                 mst       = 2;
               end
             end
          default: if (!tx_send) mst = 0;
        endcase
      end
    end
  end

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic wait_acks(input string name, input int target, input int budget);
    int n = 0;
    while (ack_cnt < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(ack_cnt >= target), 32'd1);
  endtask

  task automatic wait_sig(input string name, input bit use_active, input int budget);
    int n = 0;
    while (((use_active && !tx_active) || (!use_active && !tx_send)) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst = 1'b1;
    repeat (2) @(negedge clock);
    rst = 1'b0;
  endtask

  initial begin
    repeat (20000) @(posedge clock);
    $display("FAIL watchdog: got no finish after 20000 cycles, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst = 1'b1;
    req = '0;
    req_data = '0;
    req_cfg = '0;
    for (int i = 0; i < 4; i++) begin
      cl_data[i] = 8'h10 + 8'(i);
      cl_cfg[i]  = 4'd0;
    end
    repeat (3) @(negedge clock);

    // Reset state.
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_tx_send", 32'(tx_send), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_cfg", 32'({tx_parity_type, tx_stop_bits, tx_data_length}), 32'd0);
    check("rst_pulses", 32'({ack, done, err}), 32'd0);

    // T1: a single request from client 0.
    cl_data[0] = 8'hA5;
    cl_cfg[0]  = 4'b0111;
    apply_clients();
    push_frame(0);
    rst = 1'b0;
    req = 4'b0001;
    @(negedge clock);
    check("t1_ack_latency", 32'(ack), 32'h1);
    req = 4'b0000;
    @(negedge clock);
    check("t1_send_after_ack", 32'(tx_send), 32'd1);
    check("t1_parity", 32'(tx_parity_type), 32'h1);
    wait_drain("t1_drain", 200);
    wait_idle("t1_idle", 100);

    // T2: all four requesting from a reset pointer, giving order 0,1,2,3,0.
    do_reset();
    cl_data[0] = 8'h10; cl_cfg[0] = 4'b0000;
    cl_data[1] = 8'h11; cl_cfg[1] = 4'b0101;
    cl_data[2] = 8'h12; cl_cfg[2] = 4'b1010;
    cl_data[3] = 8'h13; cl_cfg[3] = 4'b1111;
    apply_clients();
    for (int i = 0; i < 5; i++) push_frame(i % 4);
    gap_mon_en = 1'b1;
    base = ack_cnt;
    req = 4'b1111;
    wait_acks("t2_acks", base + 5, 1000);
    req = 4'b0000;
    wait_drain("t2_drain", 400);
    gap_mon_en = 1'b0;
    wait_idle("t2_idle", 100);

    // T3: tx_done is still high from the previous frame when START is entered.
    cl_data[1] = 8'h3C; cl_cfg[1] = 4'b0010;
    apply_clients();
    act_delay = 6;
    push_frame(1);
    base = ack_cnt;
    req = 4'b0010;
    wait_acks("t3_ack", base + 1, 100);
    req = 4'b0000;
    wait_sig("t3_send", 1'b0, 50);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("t3_no_stale_done", 32'(done), 32'd0);
      check("t3_still_sending", 32'(tx_send), 32'd1);
    end
    wait_drain("t3_drain", 200);
    act_delay = 2;
    wait_idle("t3_idle", 100);

    // T4: asynchronous reset while waiting for frame completion.
    cl_data[2] = 8'h77; cl_cfg[2] = 4'b1001;
    apply_clients();
    push_frame(2);
    base = ack_cnt;
    req = 4'b0100;
    wait_acks("t4_ack", base + 1, 100);
    req = 4'b0000;
    wait_sig("t4_active", 1'b1, 50);
    @(negedge clock);
    check("t4_busy_pre", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t4_async_send", 32'(tx_send), 32'd0);
    check("t4_async_busy", 32'(busy), 32'd0);
    check("t4_async_gid", 32'(grant_id), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clock);
    rst = 1'b0;
    push_frame(0);
    base = ack_cnt;
    req = 4'b1111;
    wait_acks("t4_restart_ack", base + 1, 100);
    req = 4'b0000;
    wait_drain("t4_drain", 200);
    wait_idle("t4_idle", 100);

    // T6: req[2] drops right after ack, and its data changes; the latched frame still goes out.
    cl_data[2] = 8'h5C; cl_cfg[2] = 4'b1101;
    apply_clients();
    push_frame(2);
    base = done2_cnt;
    req = 4'b0100;
    wait_acks("t6_ack", ack_cnt + 1, 100);
    @(negedge clock);
    req = 4'b0000;
    cl_data[2] = 8'hFF; cl_cfg[2] = 4'b0000;
    apply_clients();
    wait_sig("t6_active", 1'b1, 50);
    check("t6_hold_data", 32'(tx_data), 32'h5C);
    check("t6_hold_cfg", 32'({tx_parity_type, tx_stop_bits, tx_data_length}), 32'hD);
    wait_drain("t6_drain", 200);
    wait_idle("t6_idle", 100);
    repeat (20) @(negedge clock);
    check("t6_done_once", 32'(done2_cnt - base), 32'd1);

`ifdef TX_TIMEOUT_EN
    // T5: uart_tx never goes active. Client 3 (pointer is 3) times out first, then client 0.
    model_en = 1'b0;
    cl_data[3] = 8'h33; cl_cfg[3] = 4'b0001;
    apply_clients();
    push_ev(EV_ACK, 3); push_ev(EV_ERR, 3);
    push_ev(EV_ACK, 0); push_ev(EV_ERR, 0);
    base = ack_cnt;
    req = 4'b1001;
    wait_acks("t5_acks", base + 2, 400);
    req = 4'b0000;
    wait_drain("t5_drain", 200);
    check("t5_err_latency", 32'(err_lat), 32'(TB_TO));
    wait_idle("t5_idle", 100);
    model_en = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
